mp64_sram_rmw_ctrl: RTL

//   Request front-end placed directly upstream of mp64_sram_sp. Accepts narrow

---
 rtl/mp64_sram_pkg.sv | 21 ++
 rtl/mp64_sram_rmw_ctrl_if.sv | 26 ++
 rtl/mp64_sram_word_merge.sv | 32 +++
 rtl/mp64_sram_rmw_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mp64_sram_pkg.sv
// Shared types and helpers for the mp64 SRAM request front-end.
package mp64_sram_pkg;

    localparam int WORD_W_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_RSP
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mp64_sram_rmw_ctrl_if.sv
// Narrow word request/response channel into mp64_sram_rmw_ctrl.
interface mp64_sram_rmw_ctrl_if #(
    parameter int AW     = 17,
    parameter int WORD_W = 64,
    parameter int BE_W   = WORD_W / 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [AW-1:0]     req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mp64_sram_word_merge.sv
// Byte-merges a word into one slot of a line; also returns that slot after the merge
// (with be == 0 this is simply the extracted word).
module mp64_sram_word_merge #(
    parameter int LINE_W = 512,
    parameter int WORD_W = 64,
    parameter int SEL_W  = 3
) (
    input  logic [LINE_W-1:0]   line,
    input  logic [SEL_W-1:0]    sel,
    input  logic [WORD_W-1:0]   word,
    input  logic [WORD_W/8-1:0] be,
    output logic [LINE_W-1:0]   merged,
    output logic [WORD_W-1:0]   extracted
);
    localparam int WORDS = LINE_W / WORD_W;
    localparam int BE_W  = WORD_W / 8;

    for (genvar s = 0; s < WORDS; s++) begin : g_slot
        for (genvar b = 0; b < BE_W; b++) begin : g_byte
            assign merged[s*WORD_W + b*8 +: 8] =
                (sel == SEL_W'(s) && be[b]) ? word[b*8 +: 8]
                                            : line[s*WORD_W + b*8 +: 8];
        end
    end

    always_comb begin
        extracted = '0;
        for (int s = 0; s < WORDS; s++) begin
            if (sel == SEL_W'(s)) extracted = merged[s*WORD_W +: WORD_W];
        end
    end
endmodule

// File: rtl/mp64_sram_rmw_ctrl.sv
// Word-request front-end for mp64_sram_sp; partial/strobed writes run as read-modify-write.
module mp64_sram_rmw_ctrl
    import mp64_sram_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int LINE_W  = 512,
    parameter int WORD_W  = WORD_W_DEF,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    mp64_sram_rmw_ctrl_if.slave bus,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [LINE_W-1:0] sram_wdata,
    input  logic [LINE_W-1:0] sram_rdata
);
    localparam int WORDS  = LINE_W / WORD_W;
    localparam int SEL_W  = clog2(WORDS);
    localparam int BE_W   = WORD_W / 8;
    localparam int RD_LAT = 1 + OUT_REG;
    localparam int CNT_W  = clog2(RD_LAT + 1);

    state_t state, state_n;

    logic                    we_q;
    logic [ADDR_W+SEL_W-1:0] addr_q;
    logic [WORD_W-1:0]       wdata_q;
    logic [BE_W-1:0]         be_q;
    logic [LINE_W-1:0]       line_q;
    logic [WORD_W-1:0]       rdata_q;
    logic [CNT_W-1:0]        cnt;
    logic                    wait_done;
    logic [LINE_W-1:0]       merged;
    logic [WORD_W-1:0]       word_out;

    assign wait_done = (cnt == CNT_W'(RD_LAT - 1));

    // Merge straight off the SRAM read data so the line register already holds the
    // write-back image; reads carry be_q == 0, so word_out is the untouched word.
    mp64_sram_word_merge #(
        .LINE_W (LINE_W),
        .WORD_W (WORD_W),
        .SEL_W  (SEL_W)
    ) u_merge (
        .line      (sram_rdata),
        .sel       (addr_q[SEL_W-1:0]),
        .word      (wdata_q),
        .be        (be_q),
        .merged    (merged),
        .extracted (word_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        sram_ce = 1'b0;
        sram_we = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid)
                    state_n = (bus.req_we && bus.req_be == '0) ? ST_RSP : ST_ISSUE;
            end
            ST_ISSUE: begin
                sram_ce = 1'b1;
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_done) state_n = we_q ? ST_WRITE : ST_RSP;
            end
            ST_WRITE: begin
                sram_ce = 1'b1;
                sram_we = 1'b1;
                state_n = ST_RSP;
            end
            ST_RSP: begin
                if (bus.rsp_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        be_q    <= bus.req_we ? bus.req_be : '0;
                        rdata_q <= '0;
                    end
                end
                ST_ISSUE: cnt <= '0;
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (wait_done) rdata_q <= word_out;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_WAIT && wait_done) line_q <= merged;
    end

    assign sram_addr     = addr_q[ADDR_W+SEL_W-1:SEL_W];
    assign sram_wdata    = line_q;
    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RSP);
    assign bus.rsp_rdata = rdata_q;
endmodule
